// File: rtl/pipes.sv
// Shared types and constants for the fetch/hazard pipeline controller.
package pipes;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } ctrl_state_t;

    // Instruction handed to decode together with its address.
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_data_t;

    // Sequential fetch address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Fetch sequencing plus stall/bubble/flush generation for a 5-stage pipe.
module pipeline_ctrl
    import pipes::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        i_data_ok,
    input  logic [31:0] i_data,
    input  logic        d_busy,
    input  logic        load_use,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        f_valid,
    output logic [31:0] f_inst,
    output logic [63:0] f_pc,
    output logic        stall_fd,
    output logic        stall_em,
    output logic        bubble_e,
    output logic        bubble_w,
    output logic        flush_d
);

    ctrl_state_t     state_q;
    ctrl_state_t     state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [ILEN-1:0] buf_q;
    logic [ILEN-1:0] buf_d;
    logic            redir_acc;
    fetch_data_t     fetch_out;

    // A redirect is only taken when the memory stage is not frozen.
    assign redir_acc = reset & redirect_valid & ~d_busy;

    assign ireq_addr = pc_q;
    assign f_inst    = fetch_out.inst;
    assign f_pc      = fetch_out.pc;

    // Hazard resolution: d_busy beats redirect beats load-use; silent in reset.
    always_comb begin
        stall_fd = 1'b0;
        stall_em = 1'b0;
        bubble_e = 1'b0;
        bubble_w = 1'b0;
        flush_d  = 1'b0;
        if (reset) begin
            if (d_busy) begin
                stall_fd = 1'b1;
                stall_em = 1'b1;
                bubble_w = 1'b1;
            end else if (redirect_valid) begin
                flush_d  = 1'b1;
                bubble_e = 1'b1;
            end else if (load_use) begin
                stall_fd = 1'b1;
                bubble_e = 1'b1;
            end
        end
    end

    // State, PC and held-instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state, next-PC and fetch-side outputs.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        buf_d          = buf_q;
        ireq_valid     = 1'b0;
        f_valid        = 1'b0;
        fetch_out.inst = '0;
        fetch_out.pc   = pc_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redir_acc) begin
                    pc_d = redirect_pc;
                end
            end

            FETCH: begin
                ireq_valid     = 1'b1;
                fetch_out.inst = i_data;
                if (redir_acc) begin
                    // Returning data belongs to the wrong path; an
                    // outstanding request must be drained first.
                    pc_d    = redirect_pc;
                    state_d = i_data_ok ? FETCH : DISCARD;
                end else if (i_data_ok) begin
                    if (stall_fd) begin
                        buf_d   = i_data;
                        state_d = HOLD;
                    end else begin
                        f_valid = 1'b1;
                        pc_d    = pc_next(pc_q);
                    end
                end
            end

            HOLD: begin
                fetch_out.inst = buf_q;
                if (redir_acc) begin
                    pc_d    = redirect_pc;
                    buf_d   = '0;
                    state_d = FETCH;
                end else if (!stall_fd) begin
                    f_valid = 1'b1;
                    pc_d    = pc_next(pc_q);
                    state_d = FETCH;
                end
            end

            DISCARD: begin
                ireq_valid = 1'b1;
                if (redir_acc) begin
                    pc_d = redirect_pc;
                end else if (i_data_ok) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed fetch/hazard scenarios.
module tb_pipeline_ctrl;
    import pipes::*;

    localparam logic [4:0] H_NONE = 5'b00000;
    localparam logic [4:0] H_LU   = 5'b10100;
    localparam logic [4:0] H_DB   = 5'b11010;
    localparam logic [4:0] H_RD   = 5'b00101;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        i_data_ok;
    logic [31:0] i_data;
    logic        d_busy;
    logic        load_use;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        f_valid;
    logic [31:0] f_inst;
    logic [63:0] f_pc;
    logic        stall_fd;
    logic        stall_em;
    logic        bubble_e;
    logic        bubble_w;
    logic        flush_d;

    int checks = 0;
    int errors = 0;
    fetch_data_t exp_q[$];

    pipeline_ctrl #(.PC_RESET(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .i_data_ok      (i_data_ok),
        .i_data         (i_data),
        .d_busy         (d_busy),
        .load_use       (load_use),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .f_valid        (f_valid),
        .f_inst         (f_inst),
        .f_pc           (f_pc),
        .stall_fd       (stall_fd),
        .stall_em       (stall_em),
        .bubble_e       (bubble_e),
        .bubble_w       (bubble_w),
        .flush_d        (flush_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_hz(input string nm, input logic [4:0] exp);
        chk(nm, 64'({stall_fd, stall_em, bubble_e, bubble_w, flush_d}), 64'(exp));
    endtask

    task automatic chk_req(input string nm, input logic v, input logic [63:0] addr);
        chk({nm, "_ireq_valid"}, 64'(ireq_valid), 64'(v));
        chk({nm, "_ireq_addr"}, ireq_addr, addr);
    endtask

    task automatic expect_f(input logic [31:0] inst, input logic [63:0] pc);
        fetch_data_t e;
        e.inst = inst;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic ok, input logic [31:0] d, input logic du,
                       input logic lu, input logic rv, input logic [63:0] rpc);
        @(negedge clk);
        i_data_ok      = ok;
        i_data         = d;
        d_busy         = du;
        load_use       = lu;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    // Monitor: every presented fetch must match the next scoreboard entry.
    initial begin
        fetch_data_t e;
        forever begin
            @(negedge clk);
            #2;
            if (f_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_f_valid f_inst=%h f_pc=%h", f_inst, f_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("f_inst", 64'(f_inst), 64'(e.inst));
                    chk("f_pc", f_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        i_data_ok = 1'b0; i_data = '0; d_busy = 1'b0; load_use = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        // Reset with all inputs asserted: everything must read quiet.
        @(negedge clk);
        reset = 1'b0;
        i_data_ok = 1'b1; d_busy = 1'b1; load_use = 1'b1; redirect_valid = 1'b1;
        redirect_pc = 64'h1234;
        #1;
        chk_req("rst", 1'b0, 64'h8000_0000);
        chk("rst_f_valid", 64'(f_valid), 64'd0);
        chk_hz("rst_hazards", H_NONE);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 64'h1234);
        chk_hz("rst_hazards_2", H_NONE);

        // Release: one IDLE cycle, then streaming fetch.
        @(negedge clk);
        reset = 1'b1;
        i_data_ok = 1'b1; i_data = 32'hAAAA_0000; d_busy = 1'b0; load_use = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        chk_req("idle", 1'b0, 64'h8000_0000);
        chk("idle_f_valid", 64'(f_valid), 64'd0);

        cyc(1'b1, 32'h1111_0000, 1'b0, 1'b0, 1'b0, '0);
        chk_req("seq0", 1'b1, 64'h8000_0000);
        expect_f(32'h1111_0000, 64'h8000_0000);
        cyc(1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b0, '0);
        chk_req("seq1", 1'b1, 64'h8000_0004);
        expect_f(32'h1111_0001, 64'h8000_0004);
        cyc(1'b1, 32'h1111_0002, 1'b0, 1'b0, 1'b0, '0);
        chk_req("seq2", 1'b1, 64'h8000_0008);
        expect_f(32'h1111_0002, 64'h8000_0008);

        // Load-use for two cycles: word is held, then released once.
        cyc(1'b1, 32'h2222_0003, 1'b0, 1'b1, 1'b0, '0);
        chk_req("lu0", 1'b1, 64'h8000_000C);
        chk_hz("lu0_hazards", H_LU);
        chk("lu0_f_valid", 64'(f_valid), 64'd0);
        cyc(1'b1, 32'h2222_0004, 1'b0, 1'b1, 1'b0, '0);
        chk_req("lu1", 1'b0, 64'h8000_000C);
        chk_hz("lu1_hazards", H_LU);
        chk("lu1_f_valid", 64'(f_valid), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        chk_hz("lu_rel_hazards", H_NONE);
        expect_f(32'h2222_0003, 64'h8000_000C);
        cyc(1'b1, 32'h1111_0005, 1'b0, 1'b0, 1'b0, '0);
        chk_req("lu_after", 1'b1, 64'h8000_0010);
        expect_f(32'h1111_0005, 64'h8000_0010);

        // Redirect with request outstanding: late data is discarded.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h8000_0100);
        chk_hz("rd_hazards", H_RD);
        chk("rd_f_valid", 64'(f_valid), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        chk_req("disc", 1'b1, 64'h8000_0100);
        cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, '0);
        chk("disc_late_f_valid", 64'(f_valid), 64'd0);
        cyc(1'b1, 32'h3333_0006, 1'b0, 1'b0, 1'b0, '0);
        chk_req("rd_target", 1'b1, 64'h8000_0100);
        expect_f(32'h3333_0006, 64'h8000_0100);

        // d_busy for three cycles with a pending redirect.
        cyc(1'b1, 32'h4444_0007, 1'b1, 1'b0, 1'b1, 64'h8000_0200);
        chk_hz("db0_hazards", H_DB);
        chk("db0_f_valid", 64'(f_valid), 64'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 64'h8000_0200);
        chk_hz("db1_hazards", H_DB);
        chk("db1_f_pc", f_pc, 64'h8000_0104);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 64'h8000_0200);
        chk_hz("db2_hazards", H_DB);
        chk_req("db2", 1'b0, 64'h8000_0104);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h8000_0200);
        chk_hz("db_drop_hazards", H_RD);
        chk("db_drop_f_valid", 64'(f_valid), 64'd0);
        cyc(1'b1, 32'h5555_0008, 1'b0, 1'b0, 1'b0, '0);
        chk_req("db_target", 1'b1, 64'h8000_0200);
        expect_f(32'h5555_0008, 64'h8000_0200);

        // PC wrap at the top of the address space.
        cyc(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_rd_f_valid", 64'(f_valid), 64'd0);
        cyc(1'b1, 32'h6666_0009, 1'b0, 1'b0, 1'b0, '0);
        chk_req("wrap_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_f(32'h6666_0009, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        chk_req("wrap_zero", 1'b1, 64'h0);

        // Reset asserted while discarding.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h8000_0300);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        chk_req("disc2", 1'b1, 64'h8000_0300);
        @(negedge clk);
        reset = 1'b0;
        i_data_ok = 1'b1; d_busy = 1'b1; load_use = 1'b1; redirect_valid = 1'b1;
        #1;
        chk_req("mid_rst", 1'b0, 64'h8000_0000);
        chk("mid_rst_f_valid", 64'(f_valid), 64'd0);
        chk_hz("mid_rst_hazards", H_NONE);
        @(negedge clk);
        reset = 1'b1;
        i_data_ok = 1'b0; d_busy = 1'b0; load_use = 1'b0; redirect_valid = 1'b0;
        #1;
        chk_req("mid_rel", 1'b0, 64'h8000_0000);
        cyc(1'b1, 32'h7777_000A, 1'b0, 1'b0, 1'b0, '0);
        chk_req("mid_first", 1'b1, 64'h8000_0000);
        expect_f(32'h7777_000A, 64'h8000_0000);

        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
